// File: rtl/cache_ctrl.sv
// Controller FSM in front of a direct-mapped, write-through, no-write-allocate cache.
// Optional CACHE_CTRL_STATS_EN adds saturating hit/miss/write counters.
module cache_ctrl #(
    parameter int unsigned LOG_NUM_LINES  = 2,
    parameter int unsigned LOG_NUM_BLOCKS = 1,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 8
`ifdef CACHE_CTRL_STATS_EN
    ,
    parameter int unsigned STAT_WIDTH     = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_resp_valid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cache_update,
    output logic                  cache_write_en,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_hits,
    output logic [STAT_WIDTH-1:0] stat_misses,
    output logic [STAT_WIDTH-1:0] stat_writes
`endif
);

    localparam int unsigned NUM_BLOCKS = 1 << LOG_NUM_BLOCKS;
    localparam int unsigned BEAT_W     = (LOG_NUM_BLOCKS > 0) ? LOG_NUM_BLOCKS : 1;
    localparam int unsigned TAG_LSB    = LOG_NUM_BLOCKS + LOG_NUM_LINES;

    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(NUM_BLOCKS - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_MASK  = ADDR_WIDTH'((1 << LOG_NUM_LINES) - 1);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(NUM_BLOCKS - 1);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_CHECK       = 3'd1;
    localparam logic [2:0] S_MEM_RD_REQ  = 3'd2;
    localparam logic [2:0] S_MEM_RD_WAIT = 3'd3;
    localparam logic [2:0] S_MEM_WR_REQ  = 3'd4;
    localparam logic [2:0] S_MEM_WR_WAIT = 3'd5;
    localparam logic [2:0] S_RESP        = 3'd6;

    // Word address of a given beat within the line holding addr: {tag, index, beat}.
    function automatic logic [ADDR_WIDTH-1:0] f_fill_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [BEAT_W-1:0]     beat
    );
        logic [ADDR_WIDTH-1:0] tag_part;
        logic [ADDR_WIDTH-1:0] idx_part;
        tag_part = (addr >> TAG_LSB) << TAG_LSB;
        idx_part = ((addr >> LOG_NUM_BLOCKS) & IDX_MASK) << LOG_NUM_BLOCKS;
        return tag_part | idx_part | (ADDR_WIDTH'(beat) & OFF_MASK);
    endfunction

    logic [2:0]            r_state;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BEAT_W-1:0]     r_beat;
    logic [ADDR_WIDTH-1:0] r_fill_addr;
    logic [DATA_WIDTH-1:0] r_fill_data;
    logic                  r_cpu_resp_valid;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic                  r_cache_update;
    logic                  r_cache_write_en;
    logic                  r_mem_req_valid;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic [2:0]            w_state_nxt;
    logic                  w_we_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_wdata_nxt;
    logic [BEAT_W-1:0]     w_beat_nxt;
    logic [ADDR_WIDTH-1:0] w_fill_addr_nxt;
    logic [DATA_WIDTH-1:0] w_fill_data_nxt;
    logic                  w_cpu_resp_valid_nxt;
    logic [DATA_WIDTH-1:0] w_cpu_rdata_nxt;
    logic                  w_cache_update_nxt;
    logic                  w_cache_write_en_nxt;
    logic                  w_mem_req_valid_nxt;
    logic                  w_mem_we_nxt;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0] w_mem_wdata_nxt;
    logic                  w_offset_match;
    logic                  w_last_beat;

    assign w_offset_match = ((ADDR_WIDTH'(r_beat) & OFF_MASK) == (r_addr & OFF_MASK));
    assign w_last_beat    = (r_beat == LAST_BEAT);

    // Next-state and next-output logic; registered outputs are computed one cycle ahead.
    always_comb begin
        w_state_nxt          = r_state;
        w_we_nxt             = r_we;
        w_addr_nxt           = r_addr;
        w_wdata_nxt          = r_wdata;
        w_beat_nxt           = r_beat;
        w_fill_addr_nxt      = r_fill_addr;
        w_fill_data_nxt      = r_fill_data;
        w_cpu_resp_valid_nxt = 1'b0;
        w_cpu_rdata_nxt      = r_cpu_rdata;
        w_cache_update_nxt   = 1'b0;
        w_cache_write_en_nxt = 1'b0;
        w_mem_req_valid_nxt  = r_mem_req_valid;
        w_mem_we_nxt         = r_mem_we;
        w_mem_addr_nxt       = r_mem_addr;
        w_mem_wdata_nxt      = r_mem_wdata;

        case (r_state)
            S_IDLE: begin
                if (cpu_req_valid) begin
                    w_we_nxt             = cpu_we;
                    w_addr_nxt           = cpu_addr;
                    w_wdata_nxt          = cpu_wdata;
                    // Store write strobe lands in CHECK, while cache_addr shows the request.
                    w_cache_write_en_nxt = cpu_we;
                    w_state_nxt          = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_we) begin
                    w_mem_req_valid_nxt = 1'b1;
                    w_mem_we_nxt        = 1'b1;
                    w_mem_addr_nxt      = r_addr;
                    w_mem_wdata_nxt     = r_wdata;
                    w_state_nxt         = S_MEM_WR_REQ;
                end else if (cache_hit) begin
                    w_cpu_rdata_nxt      = cache_rdata;
                    w_cpu_resp_valid_nxt = 1'b1;
                    w_state_nxt          = S_IDLE;
                end else begin
                    w_beat_nxt          = '0;
                    w_mem_req_valid_nxt = 1'b1;
                    w_mem_we_nxt        = 1'b0;
                    w_mem_addr_nxt      = f_fill_addr(r_addr, '0);
                    w_state_nxt         = S_MEM_RD_REQ;
                end
            end
            S_MEM_RD_REQ: begin
                if (mem_req_ready) begin
                    w_mem_req_valid_nxt = 1'b0;
                    w_state_nxt         = S_MEM_RD_WAIT;
                end
            end
            S_MEM_RD_WAIT: begin
                if (mem_resp_valid) begin
                    w_cache_update_nxt = 1'b1;
                    w_fill_addr_nxt    = f_fill_addr(r_addr, r_beat);
                    w_fill_data_nxt    = mem_rdata;
                    if (w_offset_match) begin
                        w_cpu_rdata_nxt = mem_rdata;
                    end
                    if (w_last_beat) begin
                        w_cpu_resp_valid_nxt = 1'b1;
                        w_state_nxt          = S_RESP;
                    end else begin
                        w_beat_nxt          = r_beat + BEAT_W'(1);
                        w_mem_req_valid_nxt = 1'b1;
                        w_mem_we_nxt        = 1'b0;
                        w_mem_addr_nxt      = f_fill_addr(r_addr, r_beat + BEAT_W'(1));
                        w_state_nxt         = S_MEM_RD_REQ;
                    end
                end
            end
            S_MEM_WR_REQ: begin
                if (mem_req_ready) begin
                    w_mem_req_valid_nxt = 1'b0;
                    w_state_nxt         = S_MEM_WR_WAIT;
                end
            end
            S_MEM_WR_WAIT: begin
                if (mem_resp_valid) begin
                    w_cpu_resp_valid_nxt = 1'b1;
                    w_state_nxt          = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_we             <= 1'b0;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_beat           <= '0;
            r_fill_addr      <= '0;
            r_fill_data      <= '0;
            r_cpu_resp_valid <= 1'b0;
            r_cpu_rdata      <= '0;
            r_cache_update   <= 1'b0;
            r_cache_write_en <= 1'b0;
            r_mem_req_valid  <= 1'b0;
            r_mem_we         <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_we             <= w_we_nxt;
            r_addr           <= w_addr_nxt;
            r_wdata          <= w_wdata_nxt;
            r_beat           <= w_beat_nxt;
            r_fill_addr      <= w_fill_addr_nxt;
            r_fill_data      <= w_fill_data_nxt;
            r_cpu_resp_valid <= w_cpu_resp_valid_nxt;
            r_cpu_rdata      <= w_cpu_rdata_nxt;
            r_cache_update   <= w_cache_update_nxt;
            r_cache_write_en <= w_cache_write_en_nxt;
            r_mem_req_valid  <= w_mem_req_valid_nxt;
            r_mem_we         <= w_mem_we_nxt;
            r_mem_addr       <= w_mem_addr_nxt;
            r_mem_wdata      <= w_mem_wdata_nxt;
        end
    end

    // Fill beats steer the cache port while cache_update is high; otherwise the request does.
    assign cache_addr     = r_cache_update ? r_fill_addr : r_addr;
    assign cache_wdata    = r_cache_update ? r_fill_data : r_wdata;
    assign cpu_req_ready  = (r_state == S_IDLE);
    assign cpu_resp_valid = r_cpu_resp_valid;
    assign cpu_rdata      = r_cpu_rdata;
    assign cache_update   = r_cache_update;
    assign cache_write_en = r_cache_write_en;
    assign mem_req_valid  = r_mem_req_valid;
    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;

`ifdef CACHE_CTRL_STATS_EN
    logic [STAT_WIDTH-1:0] r_stat_hits;
    logic [STAT_WIDTH-1:0] r_stat_misses;
    logic [STAT_WIDTH-1:0] r_stat_writes;
    logic                  w_in_check;

    assign w_in_check = (r_state == S_CHECK);

    // Classification happens once per request, in CHECK; counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
            r_stat_writes <= '0;
        end else begin
            if (w_in_check && !r_we && cache_hit && (r_stat_hits != '1)) begin
                r_stat_hits <= r_stat_hits + STAT_WIDTH'(1);
            end
            if (w_in_check && !r_we && !cache_hit && (r_stat_misses != '1)) begin
                r_stat_misses <= r_stat_misses + STAT_WIDTH'(1);
            end
            if (w_in_check && r_we && (r_stat_writes != '1)) begin
                r_stat_writes <= r_stat_writes + STAT_WIDTH'(1);
            end
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
    assign stat_writes = r_stat_writes;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural cache and memory responders around the DUT,
// checked against a memory-image / line-residency reference model.
`timescale 1ns/1ps
module tb_cache_ctrl;
    localparam int unsigned LNL = 2;
    localparam int unsigned LNB = 1;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 8;
    localparam int unsigned NL  = 1 << LNL;
    localparam int unsigned NB  = 1 << LNB;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req_valid, cpu_req_ready, cpu_we, cpu_resp_valid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cache_update, cache_write_en, cache_hit;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_wdata, cache_rdata;
    logic          mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    cache_ctrl #(
        .LOG_NUM_LINES (LNL),
        .LOG_NUM_BLOCKS(LNB),
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_resp_valid(cpu_resp_valid),
        .cpu_rdata     (cpu_rdata),
        .cache_update  (cache_update),
        .cache_write_en(cache_write_en),
        .cache_addr    (cache_addr),
        .cache_wdata   (cache_wdata),
        .cache_hit     (cache_hit),
        .cache_rdata   (cache_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment: the cache array and backing memory the controller talks to.
    logic [DW-1:0] c_data [NL][NB];
    logic          c_valid[NL];
    int            c_line [NL];
    logic [DW-1:0] mem_arr[256];
    int            ca_line, ca_idx, ca_off;

    always_comb begin
        ca_line     = int'(cache_addr) / NB;
        ca_idx      = ca_line % NL;
        ca_off      = int'(cache_addr) % NB;
        cache_hit   = c_valid[ca_idx] && (c_line[ca_idx] == ca_line);
        cache_rdata = c_data[ca_idx][ca_off];
    end

    // Reference: what memory should hold and which line each index should hold.
    logic [DW-1:0] ref_mem[256];
    bit            ref_valid[NL];
    int            ref_line[NL];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit            accepted;
    int            acc_cyc, resp_cyc;
    int            n_rd, n_wr, n_upd, n_wen, n_resp, n_stall;
    logic [DW-1:0] resp_data;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] upd_q[$];

    bit            pend;
    bit            pend_we;
    logic [AW-1:0] pend_addr;
    int            pend_cnt;
    int            fixed_delay = -1;
    int            force_low = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: capture pre-edge handshakes, advance, then play cache and memory.
    task automatic tick();
        logic          acc, mh, mwe, upd, wen, hit;
        logic [AW-1:0] ma, ca;
        logic [DW-1:0] mwd, cwd;
        int            ln, ix, of;
        acc = cpu_req_valid && cpu_req_ready;
        mh  = mem_req_valid && mem_req_ready;
        mwe = mem_we;
        ma  = mem_addr;
        mwd = mem_wdata;
        upd = cache_update;
        wen = cache_write_en;
        ca  = cache_addr;
        cwd = cache_wdata;
        hit = cache_hit;
        if (mem_req_valid && !mem_req_ready) n_stall++;
        if (upd || wen) check("upd_wen_excl", 64'(upd && wen), 64'(0));
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            accepted = 1'b1;
            acc_cyc  = cyc - 1;
        end
        ln = int'(ca) / NB;
        ix = ln % NL;
        of = int'(ca) % NB;
        if (upd) begin
            c_data[ix][of] = cwd;
            c_valid[ix]    = 1'b1;
            c_line[ix]     = ln;
            n_upd++;
            upd_q.push_back(ca);
        end
        if (wen) begin
            n_wen++;
            if (hit) c_data[ix][of] = cwd;
        end
        mem_resp_valid = 1'b0;
        mem_rdata      = $urandom;
        if (mh) begin
            if (mwe) begin
                mem_arr[ma] = mwd;
                n_wr++;
                wr_addr = ma;
                wr_data = mwd;
            end else begin
                n_rd++;
                rd_q.push_back(ma);
            end
            pend      = 1'b1;
            pend_we   = mwe;
            pend_addr = ma;
            pend_cnt  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 2));
        end
        if (pend) begin
            if (pend_cnt == 0) begin
                mem_resp_valid = 1'b1;
                if (!pend_we) mem_rdata = mem_arr[pend_addr];
                pend = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (force_low > 0) begin
            mem_req_ready = 1'b0;
            force_low--;
        end else begin
            mem_req_ready = ($urandom_range(0, 3) != 0);
        end
        if (cpu_resp_valid) begin
            n_resp++;
            resp_cyc  = cyc;
            resp_data = cpu_rdata;
        end
    endtask

    task automatic clear_counts();
        accepted = 1'b0;
        n_rd = 0; n_wr = 0; n_upd = 0; n_wen = 0; n_resp = 0; n_stall = 0;
        rd_q.delete();
        upd_q.delete();
    endtask

    task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int stall);
        int line, idx, budget, exp_fill;
        bit exp_hit;
        line     = int'(a) / NB;
        idx      = line % NL;
        exp_hit  = !we && ref_valid[idx] && (ref_line[idx] == line);
        exp_fill = (!we && !exp_hit) ? NB : 0;
        clear_counts();
        cpu_req_valid = 1'b1;
        cpu_we        = we;
        cpu_addr      = a;
        cpu_wdata     = wd;
        budget = 0;
        while (!accepted && budget < 50) begin
            tick();
            budget++;
        end
        check("accept", 64'(accepted), 64'(1));
        cpu_req_valid = 1'b0;
        cpu_we        = 1'($urandom);
        cpu_addr      = AW'($urandom);
        cpu_wdata     = $urandom;
        if (stall > 0) begin
            force_low     = stall;
            mem_req_ready = 1'b0;
        end
        budget = 0;
        while (n_resp == 0 && budget < 300) begin
            tick();
            budget++;
        end
        tick();
        tick();
        check("resp_count", 64'(n_resp), 64'(1));
        if (we) ref_mem[a] = wd;
        else if (!exp_hit) begin
            ref_valid[idx] = 1'b1;
            ref_line[idx]  = line;
        end
        if (!we) check("load_data", 64'(resp_data), 64'(ref_mem[a]));
        if (exp_hit) check("hit_latency", 64'(resp_cyc - acc_cyc), 64'(2));
        check("mem_reads", 64'(n_rd), 64'(exp_fill));
        check("cache_updates", 64'(n_upd), 64'(exp_fill));
        check("cache_write_en", 64'(n_wen), 64'(we));
        check("mem_writes", 64'(n_wr), 64'(we));
        if (we && n_wr == 1) begin
            check("wr_addr", 64'(wr_addr), 64'(a));
            check("wr_data", 64'(wr_data), 64'(wd));
        end
        if (exp_fill > 0 && rd_q.size() == exp_fill && upd_q.size() == exp_fill) begin
            for (int i = 0; i < exp_fill; i++) begin
                check("rd_addr", 64'(rd_q[i]), 64'(line * NB + i));
                check("upd_addr", 64'(upd_q[i]), 64'(line * NB + i));
            end
        end
    endtask

    initial begin
        int budget;
        rst = 1'b1;
        cpu_req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        pend = 1'b0; pend_we = 1'b0; pend_addr = '0; pend_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = $urandom;
        end
        mem_arr[8'h12] = 32'hA0;
        mem_arr[8'h13] = 32'hB1;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem_arr[i];
        for (int i = 0; i < NL; i++) begin
            c_valid[i]   = 1'b0;
            c_line[i]    = 0;
            ref_valid[i] = 1'b0;
            ref_line[i]  = 0;
            for (int j = 0; j < NB; j++) c_data[i][j] = $urandom;
        end
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 64'(cpu_resp_valid), 64'(0));
        check("rst_rdata", 64'(cpu_rdata), 64'(0));
        check("rst_mem_req", 64'(mem_req_valid), 64'(0));
        check("rst_update", 64'(cache_update), 64'(0));
        check("rst_write_en", 64'(cache_write_en), 64'(0));
        check("rst_ready", 64'(cpu_req_ready), 64'(1));
        rst = 1'b0;
        tick();

        do_req(1'b0, 8'h13, '0, 0);
        check("cold_rdata", 64'(resp_data), 64'(32'hB1));
        do_req(1'b0, 8'h12, '0, 0);
        check("hit_rdata", 64'(resp_data), 64'(32'hA0));
        do_req(1'b1, 8'h13, 32'hDEAD, 0);
        do_req(1'b0, 8'h13, '0, 0);
        check("store_hit_rdata", 64'(resp_data), 64'(32'hDEAD));
        do_req(1'b1, 8'h40, 32'h1234_5678, 2);
        do_req(1'b0, 8'h40, '0, 0);
        do_req(1'b0, 8'h33, '0, 0);
        do_req(1'b0, 8'h13, '0, 0);

        // Fill stalled by memory, then reset while the first beat is outstanding.
        fixed_delay = 4;
        clear_counts();
        cpu_req_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h25;
        budget = 0;
        while (!accepted && budget < 50) begin
            tick();
            budget++;
        end
        check("rst_test_accept", 64'(accepted), 64'(1));
        cpu_req_valid = 1'b0;
        cpu_addr      = AW'($urandom);
        force_low     = 5;
        mem_req_ready = 1'b0;
        budget = 0;
        while (n_rd == 0 && budget < 50) begin
            tick();
            budget++;
        end
        check("stall_held", 64'(n_stall >= 5), 64'(1));
        check("stall_rd_addr", 64'(mem_addr), 64'(8'h24));
        #2 rst = 1'b1;
        #1;
        check("async_resp_valid", 64'(cpu_resp_valid), 64'(0));
        check("async_rdata", 64'(cpu_rdata), 64'(0));
        check("async_mem_req", 64'(mem_req_valid), 64'(0));
        check("async_mem_we", 64'(mem_we), 64'(0));
        check("async_update", 64'(cache_update), 64'(0));
        check("async_write_en", 64'(cache_write_en), 64'(0));
        check("async_ready", 64'(cpu_req_ready), 64'(1));
        #1 rst = 1'b0;
        repeat (8) tick();
        check("stale_resp", 64'(n_resp), 64'(0));
        check("stale_update", 64'(n_upd), 64'(0));
        check("stale_reads", 64'(n_rd), 64'(1));
        fixed_delay = -1;
        do_req(1'b0, 8'h25, '0, 0);

        for (int k = 0; k < 150; k++) begin
            logic          we;
            logic [AW-1:0] a;
            we = ($urandom_range(0, 3) == 0);
            a  = AW'($urandom_range(0, 31));
            do_req(we, a, $urandom, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
